// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants, opcodes and fetch FSM state type for the rv32i core
package rv32i_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: fetch-to-decode slot register with valid/ready hold and flush
module if_id_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic        ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);
  import rv32i_pkg::*;
  logic [31:0] instr_q;
  // flush beats load, load beats consume; contents only change on a real load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      pc      <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid <= flush ? 1'b0 : load ? 1'b1 : (valid && ready) ? 1'b0 : valid;
      if (load && !flush) begin
        pc      <= in_pc;
        instr_q <= in_instr;
      end
    end
  end
  assign instr = valid ? instr_q : NOP_INSTR;
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: rv32i fetch stage, one outstanding imem request; IFETCH_ALIGN_CHECK_EN adds sticky fetch_err
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [6:0]  out_opcode
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_err
`endif
);
  import rv32i_pkg::*;
  fetch_state_t state, state_n;
  logic [31:0] pc, pc_n, req_pc, target;
  logic hs;
  assign target         = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req_valid = (state == FETCH) && (!out_valid || out_ready);
  assign imem_addr      = pc;
  assign hs             = imem_req_valid && imem_req_ready;
  // next state and pc; a redirect always wins and kills whatever is in flight
  always_comb begin
    state_n = state;
    pc_n    = redirect_valid ? target : hs ? pc + 32'd4 : pc;
    if (state == FETCH)
      state_n = hs ? (redirect_valid ? DRAIN : WAIT) : FETCH;
    else if (state == WAIT)
      state_n = imem_rsp_valid ? FETCH : redirect_valid ? DRAIN : WAIT;
    else
      state_n = imem_rsp_valid ? FETCH : DRAIN;
  end
  // state, pc and the address of the outstanding request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= FETCH;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (hs) req_pc <= pc;
    end
  end
  if_id_reg u_slot (
    .clk      (clk),
    .rst      (rst),
    .load     (state == WAIT && imem_rsp_valid),
    .flush    (redirect_valid),
    .ready    (out_ready),
    .in_pc    (req_pc),
    .in_instr (imem_rsp_data),
    .valid    (out_valid),
    .pc       (out_pc),
    .instr    (out_instr)
  );
  assign out_opcode = out_instr[6:0];
`ifdef IFETCH_ALIGN_CHECK_EN
  // sticky flag for any misaligned redirect target
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fetch_err <= 1'b0;
    else     fetch_err <= fetch_err | (redirect_valid && redirect_pc[1:0] != 2'b00);
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table + corner sequences + random scoreboard for instr_fetch
module tb_instr_fetch;
  import rv32i_pkg::*;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rsp_data, redirect_pc, out_pc, out_instr;
  logic [6:0] out_opcode;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic fetch_err;
`endif
  int n_tests = 0, n_fail = 0;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_opcode(out_opcode)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .fetch_err(fetch_err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ordy, input logic rsp, input logic rdr, input logic [31:0] rpc);
    out_ready      = ordy;
    imem_rsp_valid = rsp;
    redirect_valid = rdr;
    redirect_pc    = rpc;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  typedef struct {
    logic ordy, rsp, ereq;
    logic [31:0] eaddr;
    logic eov;
    logic [31:0] epc, einstr;
  } vec_t;
  vec_t tbl[12];

  typedef struct {
    logic [31:0] addr;
    bit killed;
    int due;
  } req_t;
  req_t q[$];

  logic m_valid, m_err, exp_req, hs, rsp;
  logic [31:0] m_pc, m_instr, m_next, exp_instr, tgt;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, NOP_INSTR};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP_INSTR};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h4, 1'b1, 32'h0, 32'h33};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP_INSTR};
    for (int i = 4; i < 9; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h4, 32'h33};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h8, 1'b1, 32'h4, 32'h33};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, NOP_INSTR};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 32'hC, 1'b1, 32'h8, 32'h33};

    drive(1'b1, 1'b0, 1'b0, 32'h0);
    imem_req_ready = 1'b1;
    imem_rsp_data  = 32'h0000_0033;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, NOP_INSTR);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("rst_fetch_err", fetch_err, 0);
`endif

    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rst = 1'b0;
      drive(tbl[i].ordy, tbl[i].rsp, 1'b0, 32'h0);
      #1;
      check($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].ereq);
      if (tbl[i].ereq) check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].eaddr);
      check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].eov);
      if (tbl[i].eov) check($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].epc);
      check($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].einstr);
      check($sformatf("tbl%0d_opcode", i), out_opcode, tbl[i].einstr[6:0]);
    end

    // redirect in WAIT, killed response arrives 3 cycles later
    @(negedge clk); drive(1'b1, 1'b0, 1'b1, 32'h100); #1;
    check("rdw_req_in_wait", imem_req_valid, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b1, i == 2, 1'b0, 32'h0); #1;
      check($sformatf("drain%0d_req", i), imem_req_valid, 0);
      check($sformatf("drain%0d_out_valid", i), out_valid, 0);
    end
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("rdw_out_valid", out_valid, 0);
    check("rdw_req", imem_req_valid, 1);
    check("rdw_addr", imem_addr, 32'h100);

    // redirect coincident with response: no DRAIN
    @(negedge clk); drive(1'b1, 1'b1, 1'b1, 32'h200); #1;
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("rdr_rsp_out_valid", out_valid, 0);
    check("rdr_rsp_req", imem_req_valid, 1);
    check("rdr_rsp_addr", imem_addr, 32'h200);

    // asynchronous reset while in WAIT
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("wait_no_req", imem_req_valid, 0);
    rst = 1'b1; #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_instr", out_instr, NOP_INSTR);
    check("arst_req", imem_req_valid, 1);
    check("arst_addr", imem_addr, 32'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("post_rst_addr", imem_addr, 32'h0);

    // misaligned redirect in FETCH without handshake
    imem_req_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 32'h102);
    @(negedge clk); imem_req_ready = 1'b1; drive(1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("mis_req", imem_req_valid, 1);
    check("mis_addr", imem_addr, 32'h100);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_err", fetch_err, 1);
`endif
    @(negedge clk); drive(1'b1, 1'b1, 1'b0, 32'h0); #1;
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 32'h0); #1;
    check("mis_slot_pc", out_pc, 32'h100);
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_err_sticky", fetch_err, 1);
`endif
    rst = 1'b1; #1;
`ifdef IFETCH_ALIGN_CHECK_EN
    check("mis_err_rst", fetch_err, 0);
`endif

    // random traffic against a transaction-level scoreboard
    m_valid = 0; m_err = 0; m_next = 32'h0; m_pc = 0; m_instr = NOP_INSTR;
    q.delete();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = 1'b0;
      out_ready      = $urandom_range(0, 3) != 0;
      imem_req_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rsp = q.size() > 0 && i >= q[0].due;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? memf(q[0].addr) : $urandom;
      #1;
      exp_req   = q.size() == 0 && !(m_valid && !out_ready);
      exp_instr = m_valid ? m_instr : NOP_INSTR;
      check("rnd_out_valid", out_valid, m_valid);
      if (m_valid) check("rnd_out_pc", out_pc, m_pc);
      check("rnd_out_instr", out_instr, exp_instr);
      check("rnd_opcode", out_opcode, exp_instr[6:0]);
      check("rnd_req_valid", imem_req_valid, exp_req);
      if (exp_req) check("rnd_addr", imem_addr, m_next);
`ifdef IFETCH_ALIGN_CHECK_EN
      check("rnd_fetch_err", fetch_err, m_err);
      m_err = m_err | (redirect_valid && redirect_pc[1:0] != 2'b00);
`endif
      hs  = exp_req && imem_req_ready;
      tgt = {redirect_pc[31:2], 2'b00};
      if (redirect_valid) m_valid = 0;
      else if (rsp && !q[0].killed) begin
        m_valid = 1; m_pc = q[0].addr; m_instr = memf(q[0].addr);
      end else if (m_valid && out_ready) m_valid = 0;
      if (rsp) void'(q.pop_front());
      if (redirect_valid) foreach (q[k]) q[k].killed = 1;
      if (hs) q.push_back('{m_next, redirect_valid, i + int'($urandom_range(1, 3))});
      m_next = redirect_valid ? tgt : hs ? m_next + 32'd4 : m_next;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
